// File: rtl/serial_servo_test_uc.sv
`timescale 1ns/1ps
// Control unit for the serial servo test: decodes received commands, drives the servo enable and echoes characters.
// Optional inactivity watchdog is compiled in with macro SERIAL_SERVO_UC_TIMEOUT_EN.
module serial_servo_test_uc #(
    parameter int TIMEOUT_CICLOS = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fim_rx,
    input  logic       parity_check,
    input  logic [6:0] data_out,
    input  logic       pronto_tx,
    output logic       partida_tx,
    output logic       zera,
    output logic       gira,
    output logic       erro,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        ESPERA        = 4'h1,
        DECODIFICA    = 4'h2,
        TRANSMITE     = 4'h3,
        AGUARDA_TX    = 4'h4,
        ERRO_PARIDADE = 4'hE
    } state_t;

    localparam logic [6:0] CHAR_L = 7'h4C;
    localparam logic [6:0] CHAR_D = 7'h44;
    localparam logic [6:0] CHAR_T = 7'h54;

    state_t state_q, state_d;
    logic   armed_q;
    logic   parity_q, parity_d;
    logic   gira_q, gira_d;
    logic   erro_q, erro_d;

`ifdef SERIAL_SERVO_UC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // armed_q holds INICIAL for one full clock after release so zera never overlaps reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= INICIAL;
            armed_q  <= 1'b0;
            parity_q <= 1'b0;
            gira_q   <= 1'b0;
            erro_q   <= 1'b0;
`ifdef SERIAL_SERVO_UC_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            armed_q  <= 1'b1;
            parity_q <= parity_d;
            gira_q   <= gira_d;
            erro_q   <= erro_d;
`ifdef SERIAL_SERVO_UC_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        gira_d   = gira_q;
        erro_d   = erro_q;
`ifdef SERIAL_SERVO_UC_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (gira_q) begin
            if (cnt_q == CNT_MAX) begin
                gira_d    = 1'b0;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif

        case (state_q)
            INICIAL: begin
                if (armed_q) state_d = ESPERA;
            end
            ESPERA: begin
                // Parity is only valid alongside fim_rx, so it is captured for the decode cycle.
                if (fim_rx) begin
                    state_d  = DECODIFICA;
                    parity_d = parity_check;
                end
            end
            DECODIFICA: begin
                if (!parity_q) begin
                    state_d = ERRO_PARIDADE;
                end else begin
                    // A valid command overrides a coincident watchdog expiry.
                    state_d = TRANSMITE;
                    erro_d  = 1'b0;
                    gira_d  = gira_q;
                    case (data_out)
                        CHAR_L:  gira_d = 1'b1;
                        CHAR_D:  gira_d = 1'b0;
                        CHAR_T:  gira_d = ~gira_q;
                        default: gira_d = gira_q;
                    endcase
`ifdef SERIAL_SERVO_UC_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            TRANSMITE: begin
                state_d = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                if (pronto_tx) state_d = ESPERA;
            end
            ERRO_PARIDADE: begin
                erro_d  = 1'b1;
                state_d = ESPERA;
            end
            default: begin
                state_d = INICIAL;
            end
        endcase
    end

    assign partida_tx = (state_q == TRANSMITE);
    assign zera       = (state_q == INICIAL) && armed_q;
    assign gira       = gira_q;
    assign erro       = erro_q;
    assign db_estado  = state_q;

`ifdef SERIAL_SERVO_UC_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_serial_servo_test_uc.sv
`timescale 1ns/1ps
// Directed testbench for serial_servo_test_uc; watchdog checks depend on SERIAL_SERVO_UC_TIMEOUT_EN.
module tb_serial_servo_test_uc;

    logic       clock;
    logic       reset;
    logic       fimRx;
    logic       parityCheck;
    logic [6:0] dataOut;
    logic       prontoTx;
    logic       partidaTx;
    logic       zera;
    logic       gira;
    logic       erro;
    logic       timeoutFlag;
    logic [3:0] dbEstado;

    int checks;
    int errors;
    int pulseCount;
    int p0;

    serial_servo_test_uc #(.TIMEOUT_CICLOS(20)) dut (
        .clock        (clock),
        .reset        (reset),
        .fim_rx       (fimRx),
        .parity_check (parityCheck),
        .data_out     (dataOut),
        .pronto_tx    (prontoTx),
        .partida_tx   (partidaTx),
        .zera         (zera),
        .gira         (gira),
        .erro         (erro),
        .timeout      (timeoutFlag),
        .db_estado    (dbEstado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Echo starts are tallied on the falling edge so each one-cycle pulse counts once.
    always @(negedge clock) begin
        if (partidaTx === 1'b1) pulseCount++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic autoStep(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            prontoTx = (dbEstado == 4'h4);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        fimRx = 1'b0;
        parityCheck = 1'b0;
        dataOut = 7'h00;
        prontoTx = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        step();
    endtask

    task automatic applyStimulus(input logic [6:0] ch, input logic par);
        dataOut = ch;
        parityCheck = par;
        fimRx = 1'b1;
        step();
        fimRx = 1'b0;
        parityCheck = ~par;
    endtask

    task automatic runChar(input logic [6:0] ch);
        applyStimulus(ch, 1'b1);
        step();
        step();
        prontoTx = 1'b1;
        step();
        prontoTx = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fimRx = 1'b0;
        parityCheck = 1'b0;
        dataOut = 7'h00;
        prontoTx = 1'b0;
        step();
        step();
        checks++; if (zera !== 1'b0) begin errors++; $display("[TB] FAIL reset_zera: got %b expected 0", zera); end
        checks++; if (dbEstado !== 4'h0) begin errors++; $display("[TB] FAIL reset_state: got %h expected 0", dbEstado); end
        checks++; if (gira !== 1'b0) begin errors++; $display("[TB] FAIL reset_gira: got %b expected 0", gira); end
        checks++; if (erro !== 1'b0) begin errors++; $display("[TB] FAIL reset_erro: got %b expected 0", erro); end
        checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeoutFlag); end
        checks++; if (partidaTx !== 1'b0) begin errors++; $display("[TB] FAIL reset_partida: got %b expected 0", partidaTx); end
        reset = 1'b1;
        #1;
        checks++; if (zera !== 1'b0) begin errors++; $display("[TB] FAIL release_zera_early: got %b expected 0", zera); end
        step();
        checks++; if (zera !== 1'b1) begin errors++; $display("[TB] FAIL inicial_zera: got %b expected 1", zera); end
        checks++; if (dbEstado !== 4'h0) begin errors++; $display("[TB] FAIL inicial_state: got %h expected 0", dbEstado); end
        step();
        checks++; if (zera !== 1'b0) begin errors++; $display("[TB] FAIL espera_zera: got %b expected 0", zera); end
        checks++; if (dbEstado !== 4'h1) begin errors++; $display("[TB] FAIL espera_state: got %h expected 1", dbEstado); end
        checks++; if (partidaTx !== 1'b0) begin errors++; $display("[TB] FAIL espera_partida: got %b expected 0", partidaTx); end
    endtask

    task automatic test_cmd_L();
        doReset();
        p0 = pulseCount;
        applyStimulus(7'h4C, 1'b1);
        checks++; if (dbEstado !== 4'h2) begin errors++; $display("[TB] FAIL L_decodifica: got %h expected 2", dbEstado); end
        checks++; if (partidaTx !== 1'b0) begin errors++; $display("[TB] FAIL L_partida_plus1: got %b expected 0", partidaTx); end
        checks++; if (gira !== 1'b0) begin errors++; $display("[TB] FAIL L_gira_plus1: got %b expected 0", gira); end
        step();
        checks++; if (dbEstado !== 4'h3) begin errors++; $display("[TB] FAIL L_transmite: got %h expected 3", dbEstado); end
        checks++; if (partidaTx !== 1'b1) begin errors++; $display("[TB] FAIL L_partida_plus2: got %b expected 1", partidaTx); end
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL L_gira: got %b expected 1", gira); end
        step();
        checks++; if (partidaTx !== 1'b0) begin errors++; $display("[TB] FAIL L_partida_plus3: got %b expected 0", partidaTx); end
        step();
        step();
        checks++; if (dbEstado !== 4'h4) begin errors++; $display("[TB] FAIL L_aguarda: got %h expected 4", dbEstado); end
        prontoTx = 1'b1;
        step();
        prontoTx = 1'b0;
        checks++; if (dbEstado !== 4'h1) begin errors++; $display("[TB] FAIL L_back_espera: got %h expected 1", dbEstado); end
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL L_echo_count: got %0d expected 1", pulseCount - p0); end
        prontoTx = 1'b1;
        step();
        prontoTx = 1'b0;
        checks++; if (dbEstado !== 4'h1) begin errors++; $display("[TB] FAIL pronto_ignored: got %h expected 1", dbEstado); end
    endtask

    task automatic test_toggle();
        doReset();
        runChar(7'h44);
        checks++; if (gira !== 1'b0) begin errors++; $display("[TB] FAIL D_gira: got %b expected 0", gira); end
        p0 = pulseCount;
        runChar(7'h54);
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL T1_gira: got %b expected 1", gira); end
        runChar(7'h54);
        checks++; if (gira !== 1'b0) begin errors++; $display("[TB] FAIL T2_gira: got %b expected 0", gira); end
        checks++; if (pulseCount - p0 !== 2) begin errors++; $display("[TB] FAIL T_echo_count: got %0d expected 2", pulseCount - p0); end
    endtask

    task automatic test_parity_error();
        doReset();
        runChar(7'h4C);
        p0 = pulseCount;
        applyStimulus(7'h44, 1'b0);
        checks++; if (dbEstado !== 4'h2) begin errors++; $display("[TB] FAIL perr_decodifica: got %h expected 2", dbEstado); end
        step();
        checks++; if (dbEstado !== 4'hE) begin errors++; $display("[TB] FAIL perr_state: got %h expected E", dbEstado); end
        checks++; if (partidaTx !== 1'b0) begin errors++; $display("[TB] FAIL perr_partida: got %b expected 0", partidaTx); end
        step();
        checks++; if (dbEstado !== 4'h1) begin errors++; $display("[TB] FAIL perr_back_espera: got %h expected 1", dbEstado); end
        checks++; if (erro !== 1'b1) begin errors++; $display("[TB] FAIL perr_erro: got %b expected 1", erro); end
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL perr_gira: got %b expected 1", gira); end
        checks++; if (pulseCount - p0 !== 0) begin errors++; $display("[TB] FAIL perr_no_echo: got %0d expected 0", pulseCount - p0); end
        applyStimulus(7'h41, 1'b1);
        step();
        checks++; if (erro !== 1'b0) begin errors++; $display("[TB] FAIL A_erro_clear: got %b expected 0", erro); end
        checks++; if (partidaTx !== 1'b1) begin errors++; $display("[TB] FAIL A_partida: got %b expected 1", partidaTx); end
        step();
        prontoTx = 1'b1;
        step();
        prontoTx = 1'b0;
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL A_gira: got %b expected 1", gira); end
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL A_echo_count: got %0d expected 1", pulseCount - p0); end
    endtask

    task automatic test_back_to_back();
        doReset();
        runChar(7'h4C);
        p0 = pulseCount;
        applyStimulus(7'h41, 1'b1);
        step();
        step();
        applyStimulus(7'h44, 1'b1);
        step();
        step();
        checks++; if (dbEstado !== 4'h4) begin errors++; $display("[TB] FAIL b2b_still_aguarda: got %h expected 4", dbEstado); end
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gira: got %b expected 1", gira); end
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL b2b_echo_count: got %0d expected 1", pulseCount - p0); end
        dataOut = 7'h44;
        parityCheck = 1'b1;
        fimRx = 1'b1;
        prontoTx = 1'b1;
        step();
        fimRx = 1'b0;
        prontoTx = 1'b0;
        checks++; if (dbEstado !== 4'h1) begin errors++; $display("[TB] FAIL both_espera: got %h expected 1", dbEstado); end
        step();
        step();
        checks++; if (dbEstado !== 4'h1) begin errors++; $display("[TB] FAIL both_dropped: got %h expected 1", dbEstado); end
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL both_gira: got %b expected 1", gira); end
        checks++; if (pulseCount - p0 !== 1) begin errors++; $display("[TB] FAIL both_echo_count: got %0d expected 1", pulseCount - p0); end
    endtask

    task automatic test_watchdog();
        logic expGira;
        logic expTimeout;
`ifdef SERIAL_SERVO_UC_TIMEOUT_EN
        expGira = 1'b0;
        expTimeout = 1'b1;
`else
        expGira = 1'b1;
        expTimeout = 1'b0;
`endif
        doReset();
        applyStimulus(7'h4C, 1'b1);
        step();
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL wd_gira_rise: got %b expected 1", gira); end
        autoStep(19);
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL wd_gira_19: got %b expected 1", gira); end
        checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("[TB] FAIL wd_timeout_19: got %b expected 0", timeoutFlag); end
        autoStep(1);
        checks++; if (gira !== expGira) begin errors++; $display("[TB] FAIL wd_gira_20: got %b expected %b", gira, expGira); end
        checks++; if (timeoutFlag !== expTimeout) begin errors++; $display("[TB] FAIL wd_timeout_20: got %b expected %b", timeoutFlag, expTimeout); end

        doReset();
        applyStimulus(7'h4C, 1'b1);
        step();
        autoStep(18);
        applyStimulus(7'h4C, 1'b1);
        step();
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL wd_L_priority_gira: got %b expected 1", gira); end
        checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("[TB] FAIL wd_L_priority_timeout: got %b expected 0", timeoutFlag); end
        autoStep(19);
        checks++; if (gira !== 1'b1) begin errors++; $display("[TB] FAIL wd_restart_39: got %b expected 1", gira); end
        autoStep(1);
        checks++; if (gira !== expGira) begin errors++; $display("[TB] FAIL wd_restart_40_gira: got %b expected %b", gira, expGira); end
        checks++; if (timeoutFlag !== expTimeout) begin errors++; $display("[TB] FAIL wd_restart_40_timeout: got %b expected %b", timeoutFlag, expTimeout); end

        doReset();
        applyStimulus(7'h4C, 1'b1);
        step();
        autoStep(10);
        reset = 1'b0;
        #1;
        checks++; if (gira !== 1'b0) begin errors++; $display("[TB] FAIL midreset_gira: got %b expected 0", gira); end
        checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("[TB] FAIL midreset_timeout: got %b expected 0", timeoutFlag); end
        checks++; if (dbEstado !== 4'h0) begin errors++; $display("[TB] FAIL midreset_state: got %h expected 0", dbEstado); end
        checks++; if (zera !== 1'b0) begin errors++; $display("[TB] FAIL midreset_zera: got %b expected 0", zera); end
        prontoTx = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulseCount = 0;
        p0 = 0;
        reset = 1'b0;
        fimRx = 1'b0;
        parityCheck = 1'b0;
        dataOut = 7'h00;
        prontoTx = 1'b0;
        $display("[TB] starting serial_servo_test_uc bench");
        test_reset();
        test_cmd_L();
        test_toggle();
        test_parity_error();
        test_back_to_back();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
